// File: rtl/stream_quantizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_quantizer_pkg
// Description : Shared types and helpers for the streaming colour quantizer:
//               control FSM state encoding, run-time mode encodings and the
//               weighted-sum width calculation.
// Ports       : none (package)
// Options     : QUANT_FRAME_CHECK_EN (used by stream_quantizer, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package stream_quantizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic MODE_WSUM = 1'b0;
  localparam logic MODE_MSB  = 1'b1;

  // Bits needed to hold the largest possible weighted sum
  // (all channels at full scale).
  function automatic int sum_width(input int ch_w, input int w_r,
                                   input int w_g, input int w_b);
    longint max_s;
    max_s = ((longint'(1) << ch_w) - 1) * longint'(w_r + w_g + w_b);
    return (max_s < 1) ? 1 : $clog2(max_s + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_quantizer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_quantizer_if
// Description : Pixel-in / index-out valid-ready bundle for stream_quantizer.
// Ports       : in_valid/in_ready/in_data/in_last  - pixel stream
//               out_valid/out_ready/q_data/q_addr  - quantized stream
//               modport master : pixel source + index sink side
//               modport slave  : the quantizer
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_quantizer_if #(
  parameter int CH_W   = 8,
  parameter int OUT_W  = 6,
  parameter int ADDR_W = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [3*CH_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    q_data;
  logic [ADDR_W-1:0]   q_addr;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, q_data, q_addr
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, q_data, q_addr
  );
endinterface
`default_nettype wire

// File: rtl/stream_quantizer_quant_core.sv
`default_nettype none
// ============================================================================
// Module      : quant_core
// Description : Two-stage quantizer datapath. Stage 1 registers the weighted
//               channel sum and the channel MSB slices; stage 2 registers
//               either floor(sum/DIV) saturated to OUT_W bits or the MSB
//               concatenation. Both stages advance only when en is high.
// Ports       : clk, rst_n       - clock, async active-low reset
//               en               - global pipeline enable
//               in_valid         - a pixel enters stage 1 this cycle
//               mode             - MODE_WSUM / MODE_MSB
//               in_data          - {R,G,B} pixel
//               out_valid/q_data - stage 2 valid and index
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
module quant_core
  import stream_quantizer_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int OUT_W = 6,
  parameter int W_R   = 16,
  parameter int W_G   = 4,
  parameter int W_B   = 1,
  parameter int DIV   = 85
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic               mode,
  input  logic [3*CH_W-1:0]  in_data,
  output logic               out_valid,
  output logic [OUT_W-1:0]   q_data
);

  localparam int               c_SUM_W = sum_width(CH_W, W_R, W_G, W_B);
  localparam int               c_SL    = OUT_W / 3;
  // Any sum at or above DIV * 2^OUT_W would produce a quotient that does not fit.
  localparam logic [63:0]      c_SAT   = 64'(DIV) << OUT_W;
  localparam logic [OUT_W-1:0] c_QMAX  = '1;

  logic [CH_W-1:0]    w_r, w_g, w_b;
  logic [c_SUM_W-1:0] w_sum;
  logic [3*c_SL-1:0]  w_msb;
  logic [OUT_W-1:0]   w_q;

  logic               v1_q;
  logic [c_SUM_W-1:0] sum_q;
  logic [3*c_SL-1:0]  msb_q;
  logic               v2_q;
  logic [OUT_W-1:0]   q_q;

  assign w_r   = in_data[3*CH_W-1 -: CH_W];
  assign w_g   = in_data[2*CH_W-1 -: CH_W];
  assign w_b   = in_data[CH_W-1:0];
  assign w_sum = c_SUM_W'(64'(w_r) * 64'(W_R) + 64'(w_g) * 64'(W_G) + 64'(w_b) * 64'(W_B));
  assign w_msb = {w_r[CH_W-1 -: c_SL], w_g[CH_W-1 -: c_SL], w_b[CH_W-1 -: c_SL]};

  always_comb begin
    w_q = c_QMAX;
    if (mode == MODE_MSB) begin
      w_q = OUT_W'(msb_q);
    end else if (64'(sum_q) < c_SAT) begin
      w_q = OUT_W'(64'(sum_q) / 64'(DIV));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      sum_q <= '0;
      msb_q <= '0;
      v2_q  <= 1'b0;
      q_q   <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sum_q <= w_sum;
        msb_q <= w_msb;
      end
      v2_q <= v1_q;
      // Bubbles leave the last index in place so q_data never glitches.
      if (v1_q) begin
        q_q <= w_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign q_data    = q_q;

endmodule
`default_nettype wire

// File: rtl/stream_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : stream_quantizer
// Description : Streaming colour quantizer. Accepts NUM_PIXELS packed {R,G,B}
//               pixels per frame after a start request and emits one colour
//               index per pixel with its frame-relative address.
// Ports       : clk, rst_n  - clock, async active-low reset
//               start, mode - frame request and mode (sampled in IDLE)
//               bus         - stream_quantizer_if.slave pixel/index streams
//               busy, done  - not-idle flag, end-of-frame pulse
//               err         - frame-length mismatch (optional feature only)
// Options     : QUANT_FRAME_CHECK_EN - adds err, checking in_last against
//               the pixel count of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_quantizer
  import stream_quantizer_pkg::*;
#(
  parameter int CH_W       = 8,
  parameter int OUT_W      = 6,
  parameter int NUM_PIXELS = 4096,
  parameter int W_R        = 16,
  parameter int W_G        = 4,
  parameter int W_B        = 1,
  parameter int DIV        = 85
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  stream_quantizer_if.slave  bus,
  output logic               busy,
`ifdef QUANT_FRAME_CHECK_EN
  output logic               err,
`endif
  output logic               done
);

  localparam int               ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  // One extra bit so the counters can hold NUM_PIXELS itself.
  localparam int               CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_NUM  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             mode_q;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic w_en, w_in_ready, w_in_fire, w_out_valid, w_out_fire, w_start_acc;

  assign w_en        = !w_out_valid || bus.out_ready;
  assign w_in_ready  = (state_q == RUN) && w_en && (in_cnt_q < c_NUM);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_start_acc = (state_q == IDLE) && start;

  quant_core #(
    .CH_W  (CH_W),
    .OUT_W (OUT_W),
    .W_R   (W_R),
    .W_G   (W_G),
    .W_B   (W_B),
    .DIV   (DIV)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_en),
    .in_valid  (w_in_fire),
    .mode      (mode_q),
    .in_data   (bus.in_data),
    .out_valid (w_out_valid),
    .q_data    (bus.q_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (in_cnt_q == c_NUM) state_d = DRAIN;
      // Leaving on the final handshake makes done land in the very next cycle.
      DRAIN: if (w_out_fire && (out_cnt_q == c_LAST)) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (w_start_acc) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (w_in_fire)  in_cnt_d  = in_cnt_q + c_ONE;
      if (w_out_fire) out_cnt_d = out_cnt_q + c_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_WSUM;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (w_start_acc) mode_q <= mode;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef QUANT_FRAME_CHECK_EN
  logic err_q;

  // A mismatch is in_last present on any pixel but the final one, or
  // absent on the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (w_start_acc) begin
      err_q <= 1'b0;
    end else if (w_in_fire && (bus.in_last != (in_cnt_q == c_LAST))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.q_addr    = out_cnt_q[ADDR_W-1:0];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

endmodule
`default_nettype wire

// File: tb/tb_stream_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_quantizer
// Description : Self-checking bench for stream_quantizer with a 16-pixel
//               frame. Expected indices come from an arithmetic model of the
//               quantization rules; addresses, latency, done and busy are
//               checked against frame-level bookkeeping.
// Options     : QUANT_FRAME_CHECK_EN - also exercises the err output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_quantizer;

  localparam int CH_W   = 8;
  localparam int OUT_W  = 6;
  localparam int NPIX   = 16;
  localparam int ADDR_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic busy;
  logic done;
`ifdef QUANT_FRAME_CHECK_EN
  logic err;
`endif

  stream_quantizer_if #(.CH_W(CH_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  stream_quantizer #(
    .CH_W       (CH_W),
    .OUT_W      (OUT_W),
    .NUM_PIXELS (NPIX),
    .W_R        (16),
    .W_G        (4),
    .W_B        (1),
    .DIV        (85)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .bus   (bus),
    .busy  (busy),
`ifdef QUANT_FRAME_CHECK_EN
    .err   (err),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          exp_q[$];
  int          acc_cyc[$];
  int          cap_q[$];
  int          acc_cnt, out_idx, done_cnt;
  bit          prev_done, lat_chk, cur_mode;
  logic [23:0] px[NPIX];

  // Reference: weighted sum floor-divided and clamped, or top two bits per channel.
  function automatic int model(logic [23:0] p, bit m);
    int r = int'(p[23:16]);
    int g = int'(p[15:8]);
    int b = int'(p[7:0]);
    int q;
    if (m) return (r / 64) * 16 + (g / 64) * 4 + (b / 64);
    q = (r * 16 + g * 4 + b) / 85;
    if (q > 63) q = 63;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_ready"},  32'(bus.in_ready),  0);
    chk({p, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({p, "_q_data"},    32'(bus.q_data),    0);
    chk({p, "_q_addr"},    32'(bus.q_addr),    0);
    chk({p, "_busy"},      32'(busy),          0);
    chk({p, "_done"},      32'(done),          0);
`ifdef QUANT_FRAME_CHECK_EN
    chk({p, "_err"},       32'(err),           0);
`endif
  endtask

  // Inputs are set at posedge+1; sample at posedge+2, then advance one clock.
  task automatic tick();
    int e, a;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        a = acc_cyc.pop_front();
        chk("q_data", 32'(bus.q_data), 32'(e));
        chk("q_addr", 32'(bus.q_addr), 32'(out_idx));
        if (lat_chk) chk("latency", 32'(cyc - a), 2);
        cap_q.push_back(int'(bus.q_data));
      end
      out_idx++;
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.in_data, cur_mode));
      acc_cyc.push_back(cyc);
      acc_cnt++;
    end
    if (prev_done) chk("busy_falls_with_done", {30'd0, busy, done}, 0);
    if (done) begin
      done_cnt++;
      chk("busy_in_fin", 32'(busy), 1);
    end
    prev_done = done;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic frame(input bit m, input bit rnd, input int last_pos,
                       input int glitch_at, input int abort_after);
    int k;
    exp_q.delete(); acc_cyc.delete(); cap_q.delete();
    acc_cnt = 0; out_idx = 0; done_cnt = 0; prev_done = 0; cur_mode = m;
    start = 1'b1; mode = m; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      if (abort_after >= 0 && acc_cnt >= abort_after) return;
      bus.in_valid  = (acc_cnt < NPIX) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      bus.in_data   = px[(acc_cnt < NPIX) ? acc_cnt : 0];
      bus.in_last   = (acc_cnt == last_pos);
      bus.out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      start         = (k == glitch_at);
      mode          = (k == glitch_at) ? !m : m;
      tick();
      k++;
    end
    start = 1'b0; mode = m; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("frame_outputs", 32'(out_idx), NPIX);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("idle_after_frame", 32'(busy), 0);
    chk("no_leftover", 32'(exp_q.size()), 0);
  endtask

  task automatic rand_px();
    for (int i = 0; i < NPIX; i++) px[i] = 24'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_not_busy", 32'(busy), 0);

    // Mode 0 directed pixels, full-rate, latency checked.
    rand_px(); px[0] = 24'hFFFFFF; px[1] = 24'h102030;
    lat_chk = 1'b1;
    frame(1'b0, 1'b0, NPIX - 1, -1, -1);
    chk("t1_first_q", 32'(cap_q[0]), 63);
    chk("t1_second_q", 32'(cap_q[1]), 5);

    // Mode 1 directed pixels.
    rand_px(); px[0] = 24'hFFFFFF; px[1] = 24'h80C040;
    frame(1'b1, 1'b0, NPIX - 1, -1, -1);
    chk("t2_first_q", 32'(cap_q[0]), 32'h3F);
    chk("t2_second_q", 32'(cap_q[1]), 32'h2D);
`ifdef QUANT_FRAME_CHECK_EN
    chk("t2_err_clean", 32'(err), 0);
`endif

    // Random data with random valid and backpressure, both modes.
    lat_chk = 1'b0;
    rand_px(); frame(1'b0, 1'b1, NPIX - 1, -1, -1);
    rand_px(); frame(1'b1, 1'b1, NPIX - 1, -1, -1);

    // Abort after 7 accepted pixels.
    rand_px();
    frame(1'b0, 1'b0, NPIX - 1, -1, 7);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk_reset("abort");
    @(posedge clk); @(posedge clk); #1;
    chk_reset("abort_hold");
    rst_n = 1'b1;
    done_cnt = 0; prev_done = 0;
    repeat (4) tick();
    chk("no_done_after_abort", 32'(done_cnt), 0);
    chk("idle_after_abort", 32'(busy), 0);
    rand_px(); frame(1'b0, 1'b1, NPIX - 1, -1, -1);

    // start (with the other mode) pulsed while running is ignored.
    rand_px(); frame(1'b0, 1'b0, NPIX - 1, 5, -1);

`ifdef QUANT_FRAME_CHECK_EN
    rand_px(); frame(1'b0, 1'b0, 9, -1, -1);
    chk("err_on_early_last", 32'(err), 1);
    repeat (3) tick();
    chk("err_sticky", 32'(err), 1);
    rand_px(); frame(1'b1, 1'b0, NPIX - 1, -1, -1);
    chk("err_clean_frame", 32'(err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
